brick_operand_sequencer: RTL and testbench
==========================================

BRICK_OPERAND_SEQUENCER -- requirements
Module: brick_operand_sequencer

Interface
REQ-001 SHALL have ports: i_clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: i_valid  in  1  operand set offered.
REQ-004 SHALL have ports: o_ready  out  1  operand set accepted when high with i_valid.
REQ-005 SHALL have ports: i_act_vec  in  128  16 activation slots of 8 bits; slot n = bits [8n+7:8n].
REQ-006 SHALL have ports: i_wgt_vec  in  128  16 weight slots of 8 bits; same layout.
REQ-007 SHALL have ports: i_prec  in  2  0 = 2-bit, 1 = 4-bit, 2 and 3 = 8-bit operands.
REQ-008 SHALL have ports: i_A_signed, i_W_signed  in  1 each  operand signedness.
REQ-009 SHALL have ports: o_valid  out  1  brick beat presented.
REQ-010 SHALL have ports: i_ready  in  1  downstream PE accepts beat.
REQ-011 SHALL have ports: o_activation, o_weight  out  32 each  16 two-bit bricks; brick n at [2n+1:2n].
REQ-012 SHALL have ports: o_A_signed, o_W_signed  out  1 each  per-beat brick signedness.
REQ-013 SHALL have ports: o_shift_amount  out  4  left shift applied to the beat's brick sum.
REQ-014 SHALL have ports: o_first, o_last  out  1 each  first and last beat of an operand set.

Function
REQ-015 SHALL capture i_act_vec, i_wgt_vec, i_prec, i_A_signed and i_W_signed on every cycle where i_valid && o_ready.
REQ-016 SHALL derive the brick count N from the captured precision: N = 1, 2 or 4.
REQ-017 SHALL issue N*N beats per operand set, at k = 0..N*N-1, with i = k / N (activation brick) and j = k % N (weight brick).
REQ-018 SHALL drive o_activation brick n = act slot n bits [2i+1:2i] and o_weight brick n = wgt slot n bits [2j+1:2j]; unused high slot bits are ignored.
REQ-019 SHALL drive o_shift_amount = 2*(i+j), range 0..12.
REQ-020 SHALL drive o_A_signed = A_signed && (i == N-1) and o_W_signed = W_signed && (j == N-1).
REQ-021 SHALL assert o_first at k = 0 and o_last at k = N*N-1; in 2-bit mode the single beat has both asserted.
REQ-022 SHALL use FSM states IDLE and ISSUE.
  - IDLE: o_valid = 0 and o_ready = 1; on accept, go to ISSUE with k = 0.
  - ISSUE: o_valid = 1; k advances only on i_valid-independent handshake o_valid && i_ready.
  - Last beat accepted with no new set: go to IDLE.
REQ-023 SHALL drive o_ready in ISSUE as o_valid && i_ready && o_last, so a new set is accepted in the same cycle as the last beat of the previous one.
REQ-024 SHALL, on that back-to-back accept, present beat 0 of the new set in the next cycle with no bubble.
REQ-025 SHALL hold all o_* beat fields stable while o_valid && !i_ready.
REQ-026 SHALL sample i_prec and the signedness inputs only at accept; changes mid-set have no effect on the set in progress.
REQ-027 SHALL have a latency of 1 cycle from accept to first o_valid.

Reset
REQ-028 SHALL, while i_rst_n = 0, force state IDLE, k = 0, o_valid = 0, o_ready = 1 and all other outputs and captured registers to 0.
REQ-029 SHALL abandon an in-progress set when reset asserts mid-set, and SHALL NOT emit its remaining beats after reset releases.

Verification
REQ-030 SHALL cover this scenario: 2-bit mode, all act slots 0x03, all wgt slots 0x02 -> one beat with o_activation = 0xFFFFFFFF, o_weight = 0xAAAAAAAA, shift 0, o_first = o_last = 1.
REQ-031 SHALL cover this scenario: 8-bit mode, act slots 0x96, wgt slots 0x1B, i_ready held high -> 16 consecutive beats; at beat k = 5, o_activation = 0x55555555, o_weight = 0xAAAAAAAA, shift 4; at beat 15, shift 12.
REQ-032 SHALL cover this scenario: 4-bit mode, i_A_signed = 1, i_W_signed = 0 -> 4 beats; o_A_signed = 0,0,1,1; o_W_signed = 0,0,0,0; shifts 0,2,2,4.
REQ-033 SHALL cover this scenario: 8-bit mode, i_ready low for 3 cycles at beat 3 -> beat 3 fields unchanged for all 4 cycles, and the set finishes 3 cycles late.
REQ-034 SHALL cover this scenario: second set offered during the last beat of a 4-bit set -> o_ready = 1 in that cycle and the next set's beat 0 follows immediately.
REQ-035 SHALL cover this scenario: i_rst_n pulsed low during beat 7 of an 8-bit set -> o_valid = 0 immediately, o_ready = 1, and no beat is emitted until a new accept.

Source files
------------

// File: rtl/brick_operand_sequencer.sv
// rtl/brick_operand_sequencer.sv - splits captured activation/weight operand sets into 2-bit brick beats
module brick_operand_sequencer (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_act_vec,
  input  logic [127:0] i_wgt_vec,
  input  logic [1:0]   i_prec,
  input  logic         i_A_signed,
  input  logic         i_W_signed,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [31:0]  o_activation,
  output logic [31:0]  o_weight,
  output logic         o_A_signed,
  output logic         o_W_signed,
  output logic [3:0]   o_shift_amount,
  output logic         o_first,
  output logic         o_last
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // Brick mode: number of 2-bit bricks per operand slot (1, 2 or 4).
  typedef enum logic [1:0] {
    MODE_N1 = 2'd0,
    MODE_N2 = 2'd1,
    MODE_N4 = 2'd2
  } mode_e;

  state_e        state_q, state_d;
  logic [3:0]    k_q, k_d;
  logic [127:0]  act_q, act_d;
  logic [127:0]  wgt_q, wgt_d;
  mode_e         mode_q, mode_d;
  logic          a_sgn_q, a_sgn_d;
  logic          w_sgn_q, w_sgn_d;

  logic [1:0]    act_idx;
  logic [1:0]    wgt_idx;
  logic [1:0]    top_idx;
  logic [3:0]    last_k;
  logic          beat_last;
  logic          accept;
  logic [31:0]   act_bricks;
  logic [31:0]   wgt_bricks;
  logic [2:0]    idx_sum;

  // Select 2-bit brick number sel out of an 8-bit operand slot.
  function automatic logic [1:0] pick_brick(input logic [7:0] slot, input logic [1:0] sel);
    logic [1:0] b;
    case (sel)
      2'd0:    b = slot[1:0];
      2'd1:    b = slot[3:2];
      2'd2:    b = slot[5:4];
      default: b = slot[7:6];
    endcase
    return b;
  endfunction

  // Map the offered precision onto a brick mode; 2 and 3 both mean 8-bit.
  function automatic mode_e prec_to_mode(input logic [1:0] prec);
    mode_e m;
    case (prec)
      2'd0:    m = MODE_N1;
      2'd1:    m = MODE_N2;
      default: m = MODE_N4;
    endcase
    return m;
  endfunction

  // Split the beat counter into activation brick i and weight brick j.
  always_comb begin
    act_idx = 2'd0;
    wgt_idx = 2'd0;
    top_idx = 2'd0;
    last_k  = 4'd0;
    case (mode_q)
      MODE_N1: begin
        act_idx = 2'd0;
        wgt_idx = 2'd0;
        top_idx = 2'd0;
        last_k  = 4'd0;
      end
      MODE_N2: begin
        act_idx = {1'b0, k_q[1]};
        wgt_idx = {1'b0, k_q[0]};
        top_idx = 2'd1;
        last_k  = 4'd3;
      end
      default: begin
        act_idx = k_q[3:2];
        wgt_idx = k_q[1:0];
        top_idx = 2'd3;
        last_k  = 4'd15;
      end
    endcase
  end

  assign beat_last = (k_q == last_k);
  assign idx_sum   = {1'b0, act_idx} + {1'b0, wgt_idx};

  // Gather the selected brick from each of the 16 slots.
  always_comb begin
    act_bricks = '0;
    wgt_bricks = '0;
    for (int n = 0; n < 16; n++) begin
      act_bricks[2*n +: 2] = pick_brick(act_q[8*n +: 8], act_idx);
      wgt_bricks[2*n +: 2] = pick_brick(wgt_q[8*n +: 8], wgt_idx);
    end
  end

  // Beat outputs; everything is quiet outside ISSUE so idle/reset shows zeros.
  always_comb begin
    o_valid        = 1'b0;
    o_ready        = 1'b0;
    o_activation   = '0;
    o_weight       = '0;
    o_A_signed     = 1'b0;
    o_W_signed     = 1'b0;
    o_shift_amount = '0;
    o_first        = 1'b0;
    o_last         = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
      end
      ISSUE: begin
        o_valid        = 1'b1;
        // A new set may only enter as the final beat of the current one leaves.
        o_ready        = i_ready && beat_last;
        o_activation   = act_bricks;
        o_weight       = wgt_bricks;
        o_A_signed     = a_sgn_q && (act_idx == top_idx);
        o_W_signed     = w_sgn_q && (wgt_idx == top_idx);
        o_shift_amount = {idx_sum, 1'b0};
        o_first        = (k_q == 4'd0);
        o_last         = beat_last;
      end
      default: begin
        o_ready = 1'b1;
      end
    endcase
  end

  assign accept = i_valid && o_ready;

  // Next state: capture on accept, otherwise step k on each accepted beat.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    act_d   = act_q;
    wgt_d   = wgt_q;
    mode_d  = mode_q;
    a_sgn_d = a_sgn_q;
    w_sgn_d = w_sgn_q;
    if (accept) begin
      state_d = ISSUE;
      k_d     = 4'd0;
      act_d   = i_act_vec;
      wgt_d   = i_wgt_vec;
      mode_d  = prec_to_mode(i_prec);
      a_sgn_d = i_A_signed;
      w_sgn_d = i_W_signed;
    end else if (state_q == ISSUE && i_ready) begin
      if (beat_last) begin
        state_d = IDLE;
        k_d     = 4'd0;
      end else begin
        k_d = k_q + 4'd1;
      end
    end
  end

  // State and captured operand registers; reset abandons any set in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      act_q   <= '0;
      wgt_q   <= '0;
      mode_q  <= MODE_N1;
      a_sgn_q <= 1'b0;
      w_sgn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      act_q   <= act_d;
      wgt_q   <= wgt_d;
      mode_q  <= mode_d;
      a_sgn_q <= a_sgn_d;
      w_sgn_q <= w_sgn_d;
    end
  end

endmodule

// File: tb/tb_brick_operand_sequencer.sv
// tb/tb_brick_operand_sequencer.sv - directed self-checking bench for brick_operand_sequencer
module tb_brick_operand_sequencer;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] i_act_vec;
  logic [127:0] i_wgt_vec;
  logic [1:0]   i_prec;
  logic         i_A_signed;
  logic         i_W_signed;
  logic         o_valid;
  logic         i_ready;
  logic [31:0]  o_activation;
  logic [31:0]  o_weight;
  logic         o_A_signed;
  logic         o_W_signed;
  logic [3:0]   o_shift_amount;
  logic         o_first;
  logic         o_last;

  brick_operand_sequencer dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_act_vec      (i_act_vec),
    .i_wgt_vec      (i_wgt_vec),
    .i_prec         (i_prec),
    .i_A_signed     (i_A_signed),
    .i_W_signed     (i_W_signed),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_activation   (o_activation),
    .o_weight       (o_weight),
    .o_A_signed     (o_A_signed),
    .o_W_signed     (o_W_signed),
    .o_shift_amount (o_shift_amount),
    .o_first        (o_first),
    .o_last         (o_last)
  );

  typedef struct {
    logic [31:0] act;
    logic [31:0] wgt;
    logic [3:0]  sh;
    logic        as;
    logic        ws;
    logic        first;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t log_q[$];
  beat_t stall_q[$];
  int    tests_run;
  int    tests_failed;
  int    cyc;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Record every accepted beat, sampled mid-cycle.
  always begin
    @(negedge i_clk);
    #2;
    if (i_rst_n && o_valid && i_ready)
      log_q.push_back(snap());
  end

  function automatic beat_t snap();
    beat_t b;
    b.act = o_activation;
    b.wgt = o_weight;
    b.sh = o_shift_amount;
    b.as = o_A_signed;
    b.ws = o_W_signed;
    b.first = o_first;
    b.last = o_last;
    b.cyc = cyc;
    return b;
  endfunction

  function automatic beat_t get(input int idx);
    beat_t b;
    b = '{act: 32'hDEADBEEF, wgt: 32'hDEADBEEF, sh: 4'hF, as: 1'bx, ws: 1'bx, first: 1'bx, last: 1'bx, cyc: -1000};
    if (idx >= 0 && idx < log_q.size()) b = log_q[idx];
    return b;
  endfunction

  function automatic logic [127:0] rep(input logic [7:0] v);
    return {16{v}};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [7:0] a, input logic [7:0] w, input logic [1:0] p,
                       input logic as, input logic ws);
    @(negedge i_clk);
    i_act_vec  = rep(a);
    i_wgt_vec  = rep(w);
    i_prec     = p;
    i_A_signed = as;
    i_W_signed = ws;
    i_valid    = 1'b1;
    #1 check("offer_ready", {31'd0, o_ready}, 32'd1);
    @(posedge i_clk);
    #1 i_valid = 1'b0;
  endtask

  // Run beats until o_valid drops, optionally holding i_ready low at one beat.
  task automatic drain(input int stall_at, input int stall_len);
    int  stalled;
    bit  done;
    stalled = 0;
    done = 0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge i_clk);
      if (log_q.size() == stall_at && stalled < stall_len) begin
        i_ready = 1'b0;
        stalled++;
        #1 stall_q.push_back(snap());
      end else begin
        i_ready = 1'b1;
        #1;
      end
      if (!o_valid) done = 1;
    end
    i_ready = 1'b1;
    check("drain_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int sh_exp[4];
    int as_exp[4];
    int wgt_exp[4];
    bit b_sent;
    cyc        = 0;
    tests_run  = 0;
    tests_failed = 0;
    i_rst_n    = 1'b0;
    i_valid    = 1'b0;
    i_ready    = 1'b1;
    i_act_vec  = '0;
    i_wgt_vec  = '0;
    i_prec     = 2'd0;
    i_A_signed = 1'b0;
    i_W_signed = 1'b0;

    // Reset state
    repeat (3) @(negedge i_clk);
    #1;
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_act", o_activation, 32'd0);
    check("rst_first", {31'd0, o_first}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // 2-bit single beat
    log_q.delete();
    offer(8'h03, 8'h02, 2'd0, 1'b0, 1'b0);
    @(negedge i_clk);
    #1;
    check("b2_latency_valid", {31'd0, o_valid}, 32'd1);
    drain(-1, 0);
    check("b2_count", log_q.size(), 32'd1);
    check("b2_act", get(0).act, 32'hFFFFFFFF);
    check("b2_wgt", get(0).wgt, 32'hAAAAAAAA);
    check("b2_shift", {28'd0, get(0).sh}, 32'd0);
    check("b2_first", {31'd0, get(0).first}, 32'd1);
    check("b2_last", {31'd0, get(0).last}, 32'd1);

    // 8-bit, ready held high
    log_q.delete();
    offer(8'h96, 8'h1B, 2'd2, 1'b0, 1'b0);
    drain(-1, 0);
    check("b8_count", log_q.size(), 32'd16);
    check("b8_k0_act", get(0).act, 32'hAAAAAAAA);
    check("b8_k0_wgt", get(0).wgt, 32'hFFFFFFFF);
    check("b8_k5_act", get(5).act, 32'h55555555);
    check("b8_k5_wgt", get(5).wgt, 32'hAAAAAAAA);
    check("b8_k5_shift", {28'd0, get(5).sh}, 32'd4);
    check("b8_k15_shift", {28'd0, get(15).sh}, 32'd12);
    check("b8_k15_act", get(15).act, 32'hAAAAAAAA);
    check("b8_k15_last", {31'd0, get(15).last}, 32'd1);
    check("b8_k14_last", {31'd0, get(14).last}, 32'd0);
    check("b8_span", get(15).cyc - get(0).cyc, 32'd15);

    // 4-bit signed activations; inputs change mid-set and high slot bits are junk
    log_q.delete();
    offer(8'hFE, 8'hF4, 2'd1, 1'b1, 1'b0);
    i_prec = 2'd0;
    i_A_signed = 1'b0;
    i_W_signed = 1'b1;
    drain(-1, 0);
    sh_exp  = '{0, 2, 2, 4};
    as_exp  = '{0, 0, 1, 1};
    wgt_exp = '{32'h0, 32'h55555555, 32'h0, 32'h55555555};
    check("b4_count", log_q.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b4_k%0d_shift", k), {28'd0, get(k).sh}, sh_exp[k]);
      check($sformatf("b4_k%0d_asgn", k), {31'd0, get(k).as}, as_exp[k]);
      check($sformatf("b4_k%0d_wsgn", k), {31'd0, get(k).ws}, 32'd0);
      check($sformatf("b4_k%0d_wgt", k), get(k).wgt, wgt_exp[k]);
    end
    check("b4_k0_act", get(0).act, 32'hAAAAAAAA);
    check("b4_k3_act", get(3).act, 32'hFFFFFFFF);

    // 8-bit with a 3-cycle stall at beat 3
    log_q.delete();
    stall_q.delete();
    offer(8'h96, 8'h1B, 2'd3, 1'b0, 1'b0);
    drain(3, 3);
    check("stall_count", log_q.size(), 32'd16);
    check("stall_snaps", stall_q.size(), 32'd3);
    for (int s = 0; s < stall_q.size(); s++) begin
      check($sformatf("stall%0d_act", s), stall_q[s].act, 32'hAAAAAAAA);
      check($sformatf("stall%0d_wgt", s), stall_q[s].wgt, 32'h00000000);
      check($sformatf("stall%0d_shift", s), {28'd0, stall_q[s].sh}, 32'd6);
    end
    check("stall_k3_act", get(3).act, 32'hAAAAAAAA);
    check("stall_k3_shift", {28'd0, get(3).sh}, 32'd6);
    check("stall_span", get(15).cyc - get(0).cyc, 32'd18);

    // Back-to-back: second set offered on the last beat of a 4-bit set
    log_q.delete();
    offer(8'h0E, 8'h0E, 2'd1, 1'b0, 1'b0);
    b_sent = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      i_ready = 1'b1;
      if (log_q.size() == 3 && !b_sent) begin
        i_act_vec = rep(8'h07);
        i_wgt_vec = rep(8'h09);
        i_prec    = 2'd1;
        i_valid   = 1'b1;
        b_sent    = 1;
        #1;
        check("b2b_ready", {31'd0, o_ready}, 32'd1);
        check("b2b_last", {31'd0, o_last}, 32'd1);
        @(posedge i_clk);
        #1 i_valid = 1'b0;
      end else begin
        #1;
        if (!o_valid) break;
      end
    end
    check("b2b_sent", {31'd0, b_sent}, 32'd1);
    check("b2b_count", log_q.size(), 32'd8);
    check("b2b_first", {31'd0, get(4).first}, 32'd1);
    check("b2b_gap", get(4).cyc - get(3).cyc, 32'd1);
    check("b2b_act", get(4).act, 32'hFFFFFFFF);
    check("b2b_wgt", get(4).wgt, 32'h55555555);
    check("b2b_end", {31'd0, get(7).last}, 32'd1);

    // Reset pulse during beat 7 of an 8-bit set
    log_q.delete();
    offer(8'h96, 8'h1B, 2'd2, 1'b1, 1'b1);
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (log_q.size() == 7) begin
        i_rst_n = 1'b0;
        #1;
        check("mrst_valid", {31'd0, o_valid}, 32'd0);
        check("mrst_ready", {31'd0, o_ready}, 32'd1);
        check("mrst_shift", {28'd0, o_shift_amount}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        break;
      end
    end
    repeat (5) @(negedge i_clk);
    #1;
    check("mrst_idle_valid", {31'd0, o_valid}, 32'd0);
    check("mrst_beats", log_q.size(), 32'd7);

    // Recovery with a fresh set
    log_q.delete();
    offer(8'h01, 8'h03, 2'd0, 1'b0, 1'b0);
    drain(-1, 0);
    check("rec_count", log_q.size(), 32'd1);
    check("rec_act", get(0).act, 32'h55555555);
    check("rec_wgt", get(0).wgt, 32'hFFFFFFFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
